csa_pipe_adder: RTL and testbench



---
 rtl/csa_pipe_adder.sv | 162 ++++++++++++++++
 tb/tb_csa_pipe_adder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder.sv
// Pipelined conditional-sum adder/subtractor with valid/ready flow control.
// The merge tree is either fully registered per level or a single combinational block.
module csa_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LVL = $clog2(WIDTH);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Operand conditioning: subtraction is a + ~b + 1
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub ? 1'b1 : cin;
  end

  logic [WIDTH-1:0] st_s0, st_s1, st_c0, st_c1;
  logic             st_cin, st_am, st_bm, st_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v   <= 1'b0;
      st_s0  <= '0;
      st_s1  <= '0;
      st_c0  <= '0;
      st_c1  <= '0;
      st_cin <= 1'b0;
      st_am  <= 1'b0;
      st_bm  <= 1'b0;
    end else if (en) begin
      st_v   <= in_valid;
      st_s0  <= a ^ b_eff;
      st_c0  <= a & b_eff;
      st_s1  <= ~(a ^ b_eff);
      st_c1  <= a | b_eff;
      st_cin <= c_eff;
      st_am  <= a[WIDTH-1];
      st_bm  <= b_eff[WIDTH-1];
    end
  end

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int unsigned NB = WIDTH >> k;
    localparam int unsigned H  = 1 << (k - 1);

    logic [WIDTH-1:0] is0, is1, ms0, ms1, os0, os1;
    logic [2*NB-1:0]  ic0, ic1;
    logic [NB-1:0]    mc0, mc1, oc0, oc1;
    logic             icin, iam, ibm, iv;
    logic             ocin, oam, obm, ov;

    if (k == 1) begin : g_src
      assign is0  = st_s0;
      assign is1  = st_s1;
      assign ic0  = st_c0;
      assign ic1  = st_c1;
      assign icin = st_cin;
      assign iam  = st_am;
      assign ibm  = st_bm;
      assign iv   = st_v;
    end else begin : g_src
      assign is0  = g_lvl[k-1].os0;
      assign is1  = g_lvl[k-1].os1;
      assign ic0  = g_lvl[k-1].oc0;
      assign ic1  = g_lvl[k-1].oc1;
      assign icin = g_lvl[k-1].ocin;
      assign iam  = g_lvl[k-1].oam;
      assign ibm  = g_lvl[k-1].obm;
      assign iv   = g_lvl[k-1].ov;
    end

    // Upper half of each block picks its pair using the lower half's carry
    for (genvar j = 0; j < NB; j++) begin : g_blk
      localparam int unsigned LO = j * 2 * H;
      localparam int unsigned HI = LO + H;
      assign ms0[LO +: H] = is0[LO +: H];
      assign ms1[LO +: H] = is1[LO +: H];
      assign ms0[HI +: H] = ic0[2*j] ? is1[HI +: H] : is0[HI +: H];
      assign ms1[HI +: H] = ic1[2*j] ? is1[HI +: H] : is0[HI +: H];
      assign mc0[j]       = ic0[2*j] ? ic1[2*j+1] : ic0[2*j+1];
      assign mc1[j]       = ic1[2*j] ? ic1[2*j+1] : ic0[2*j+1];
    end

    // The last level feeds the output register directly
    if (PIPE != 0 && k < LVL) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov   <= 1'b0;
          os0  <= '0;
          os1  <= '0;
          oc0  <= '0;
          oc1  <= '0;
          ocin <= 1'b0;
          oam  <= 1'b0;
          obm  <= 1'b0;
        end else if (en) begin
          ov   <= iv;
          os0  <= ms0;
          os1  <= ms1;
          oc0  <= mc0;
          oc1  <= mc1;
          ocin <= icin;
          oam  <= iam;
          obm  <= ibm;
        end
      end
    end else begin : g_comb
      assign ov   = iv;
      assign os0  = ms0;
      assign os1  = ms1;
      assign oc0  = mc0;
      assign oc1  = mc1;
      assign ocin = icin;
      assign oam  = iam;
      assign obm  = ibm;
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;

  // Final select by the real carry-in
  always_comb begin
    sum_d  = g_lvl[LVL].ocin ? g_lvl[LVL].os1 : g_lvl[LVL].os0;
    cout_d = g_lvl[LVL].ocin ? g_lvl[LVL].oc1[0] : g_lvl[LVL].oc0[0];
    ovf_d  = (g_lvl[LVL].oam == g_lvl[LVL].obm) && (sum_d[WIDTH-1] != g_lvl[LVL].oam);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= g_lvl[LVL].ov;
      sum       <= sum_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: 16-bit pipelined DUT under flow control, plus 8-bit
// combinational and 64-bit pipelined builds checked against an arithmetic model.
module tb_csa_pipe_adder;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b, sum;
  logic        in_ready, out_valid, cout, ovf;

  logic [7:0]  a8, b8, sum8;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [63:0] a64, b64, sum64;
  logic        in_ready64, out_valid64, cout64, ovf64;

  csa_pipe_adder #(.WIDTH(16), .PIPE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  csa_pipe_adder #(.WIDTH(8), .PIPE(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin), .sub(sub), .out_valid(out_valid8),
    .out_ready(1'b1), .sum(sum8), .cout(cout8), .ovf(ovf8));

  csa_pipe_adder #(.WIDTH(64), .PIPE(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a64), .b(b64), .cin(cin), .sub(sub), .out_valid(out_valid64),
    .out_ready(1'b1), .sum(sum64), .cout(cout64), .ovf(ovf64));

  int   tests = 0, fails = 0, cyc = 0, pops16 = 0, acc_cyc = 0;
  bit   lat_chk = 1'b1, rnd_bp = 1'b0, hold_prev = 1'b0;
  logic [15:0] prev_sum;
  logic [1:0]  prev_flags;
  exp_t q16[$], q8[$], q64[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: result with no accepted operands (cycle %0d)", nm, cyc);
  endtask

  // Reference: plain modular arithmetic on w-bit operands
  function automatic exp_t model(input int unsigned w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic cv, input logic sv);
    exp_t        r;
    logic [63:0] m, be, aa;
    logic [64:0] full;
    int unsigned msb;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = av & m;
    be   = (sv ? ~bv : bv) & m;
    full = {1'b0, aa} + {1'b0, be} + 65'(sv ? 1'b1 : cv);
    msb  = w - 1;
    r.sum  = full[63:0] & m;
    r.cout = full[w];
    r.ovf  = (aa[msb] == be[msb]) && (r.sum[msb] != aa[msb]);
    r.cyc  = 0;
    r.lat  = 1'b0;
    return r;
  endfunction

  // Single compare process for all three DUTs
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q16.delete(); q8.delete(); q64.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        chk("hold", {out_valid, cout, ovf, sum}, {1'b1, prev_flags, prev_sum});
      if (out_valid && out_ready) begin
        if (q16.size() == 0) spurious("out16");
        else begin
          e = q16.pop_front();
          chk("sum16", 64'(sum), e.sum);
          chk("flags16", 64'({cout, ovf}), 64'({e.cout, e.ovf}));
          if (e.lat) chk("lat16", 64'(cyc - e.cyc), 64'd5);
          pops16++;
        end
      end
      hold_prev  = out_valid && !out_ready;
      prev_sum   = sum;
      prev_flags = {cout, ovf};
      if (out_valid8) begin
        if (q8.size() == 0) spurious("out8");
        else begin
          e = q8.pop_front();
          chk("sum8", 64'(sum8), e.sum);
          chk("flags8", 64'({cout8, ovf8}), 64'({e.cout, e.ovf}));
          chk("lat8", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (out_valid64) begin
        if (q64.size() == 0) spurious("out64");
        else begin
          e = q64.pop_front();
          chk("sum64", sum64, e.sum);
          chk("flags64", 64'({cout64, ovf64}), 64'({e.cout, e.ovf}));
          chk("lat64", 64'(cyc - e.cyc), 64'd7);
        end
      end
      if (in_valid && in_ready) begin
        e = model(16, 64'(a), 64'(b), cin, sub); e.cyc = cyc; e.lat = lat_chk; q16.push_back(e);
      end
      if (in_valid && in_ready8) begin
        e = model(8, 64'(a8), 64'(b8), cin, sub); e.cyc = cyc; q8.push_back(e);
      end
      if (in_valid && in_ready64) begin
        e = model(64, a64, b64, cin, sub); e.cyc = cyc; q64.push_back(e);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge
  task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic cv, input logic sv);
    int n;
    a = av[15:0]; b = bv[15:0]; a8 = av[7:0]; b8 = bv[7:0]; a64 = av; b64 = bv;
    cin = cv; sub = sv; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stuck at 0 (cycle %0d)", cyc);
    end
    acc_cyc = cyc;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run_one(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv, input logic [15:0] es,
                         input logic ec, input logic eo);
    bit found = 1'b0;
    drive(64'(av), 64'(bv), cv, sv);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1'b1; break; end
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL %s: no out_valid within 20 cycles", nm);
    end else begin
      chk({nm, "_sum"}, 64'(sum), 64'(es));
      chk({nm, "_cout_ovf"}, 64'({cout, ovf}), 64'({ec, eo}));
      chk({nm, "_latency"}, 64'(cyc - acc_cyc), 64'd5);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   p0, cnt;
    bit   found;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0; a64 = '0; b64 = '0;

    e = model(16, 64'h5, 64'h7, 1'b0, 1'b1);
    chk("pin_model_sub", {e.ovf, e.cout, e.sum}, {2'b00, 64'hFFFE});
    e = model(8, 64'h7F, 64'h01, 1'b0, 1'b0);
    chk("pin_model_ovf8", {e.ovf, e.cout, e.sum}, {2'b10, 64'h80});
    e = model(64, '1, 64'h0, 1'b1, 1'b0);
    chk("pin_model_wrap64", {e.ovf, e.cout, e.sum}, {2'b01, 64'h0});

    #12;
    chk("rst_state", 64'({out_valid, cout, ovf, sum}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_aux_valid", 64'({out_valid8, out_valid64}), 64'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #2;

    run_one("add_small", 16'h0001, 16'h0003, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
    run_one("add_minmin", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_one("add_wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("sub_equal", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_one("add_zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_one("add_posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_cin_ign", 16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Back-pressure: 8-vector stream, out_ready low for 3 cycles after the first result
    lat_chk = 1'b0;
    p0 = pops16;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive(64'(16'h1000 + 16'(i) * 16'h0111), 64'(16'h0F00 - 16'(i)), 1'(i), 1'(i >> 1));
      end
      begin
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
          @(negedge clk);
          found = out_valid;
        end
        @(posedge clk); #2;
        out_ready = 1'b0;
        #1 chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    idle(15);
    chk("bp_result_count", 64'(pops16 - p0), 64'd8);

    // Random traffic with random back-pressure and bubbles
    rnd_bp = 1'b1;
    fork
      begin
        while (rnd_bp) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 7) == 0) idle(1);
          drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end
        rnd_bp = 1'b0;
      end
    join
    idle(2);

    // Full-rate random stream, latency checked
    lat_chk = 1'b1;
    for (int i = 0; i < 60; i++)
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    idle(20);
    chk("drain_q16", 64'(q16.size()), 64'd0);
    chk("drain_q8", 64'(q8.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);

    // Reset with results in flight and a stalled valid output
    lat_chk = 1'b0;
    out_ready = 1'b0;
    drive(64'h0111, 64'h0222, 1'b0, 1'b0);
    drive(64'h0333, 64'h0444, 1'b1, 1'b0);
    drive(64'h0555, 64'h0111, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    chk("rst_inflight", 64'(q16.size()), 64'd3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_sum", 64'({cout, ovf, sum}), 64'd0);
    chk("rst_async_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || out_valid8 || out_valid64) cnt++;
    end
    chk("rst_no_stale", 64'(cnt), 64'd0);
    @(posedge clk); #2;

    run_one("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
